// File: rtl/asc_pkg.sv
// Shared codes for the elevator scheduler:
// floors, directions, FSM states and request masks.
package asc_pkg;

    localparam logic [1:0] PISO_M1 = 2'b00;
    localparam logic [1:0] PISO_1  = 2'b01;
    localparam logic [1:0] PISO_2  = 2'b10;
    localparam logic [1:0] PISO_3  = 2'b11;

    localparam logic [1:0] DIR_NADA = 2'b00;
    localparam logic [1:0] DIR_SUBE = 2'b01;
    localparam logic [1:0] DIR_BAJA = 2'b10;

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        MOVIENDO = 2'b01,
        PUERTAS  = 2'b10
    } estado_e;

    function automatic logic [3:0] uno_caliente(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

    function automatic logic [3:0] mascara_arriba(input logic [1:0] p);
        return 4'b1110 << p;
    endfunction

    function automatic logic [3:0] mascara_abajo(input logic [1:0] p);
        return uno_caliente(p) - 4'd1;
    endfunction

endpackage

// File: rtl/temporizador_asc.sv
// Shared up-counter for travel and door dwell.
// fin marks the last cycle of the selected phase.
module temporizador_asc #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         limpiar,
    input  logic         habilitar,
    input  logic [W-1:0] limite,
    output logic         fin
);

    logic [W-1:0] cuenta_q;
    logic [W-1:0] cuenta_d;

    // Terminal count only counts while the phase is running.
    always_comb begin
        fin      = habilitar && (cuenta_q == limite);
        cuenta_d = cuenta_q;
        if (limpiar || fin) begin
            cuenta_d = '0;
        end else if (habilitar) begin
            cuenta_d = cuenta_q + 1'b1;
        end
    end

    // Count register, dropped to zero by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

endmodule

// File: rtl/planificador_asc.sv
// SCAN call scheduler and motion sequencer for the
// four-stop elevator (floors -1, 1, 2, 3).
module planificador_asc
    import asc_pkg::*;
#(
    parameter int unsigned T_VIAJE    = 50000000,
    parameter int unsigned T_PUERTA   = 100000000,
    parameter logic [1:0]  PISO_RESET = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] llamadas,
    output logic [1:0] piso,
    output logic [1:0] direccion,
    output logic       puertas_abiertas,
    output logic [3:0] pendientes
);

    localparam int unsigned T_MAX =
        (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int unsigned TW = $clog2(T_MAX);
    localparam logic [TW-1:0] FIN_VIAJE  = TW'(T_VIAJE - 1);
    localparam logic [TW-1:0] FIN_PUERTA = TW'(T_PUERTA - 1);

    estado_e     estado_q, estado_d;
    logic [1:0]  piso_q, piso_d;
    logic [1:0]  dir_q, dir_d;
    logic [3:0]  pend_q, pend_d;

    logic [3:0]    ver;
    logic          arriba, abajo, aqui;
    logic          sube;
    logic [1:0]    piso_sig;
    logic          tope;
    logic          ver_sig;
    logic          adelante_sig;
    logic [3:0]    borrar;
    logic          extender;
    logic          limpiar;
    logic          habilitar;
    logic [TW-1:0] limite;
    logic          fin;

    // Request view: latched calls plus this cycle's buttons.
    always_comb begin
        ver    = pend_q | llamadas;
        arriba = |(ver & mascara_arriba(piso_q));
        abajo  = |(ver & mascara_abajo(piso_q));
        aqui   = ver[piso_q];
        sube   = (dir_q == DIR_SUBE);
        tope   = sube ? (piso_q == PISO_3)
                      : (piso_q == PISO_M1);
        if (tope) begin
            piso_sig = piso_q;
        end else if (sube) begin
            piso_sig = piso_q + 2'd1;
        end else begin
            piso_sig = piso_q - 2'd1;
        end
        ver_sig      = ver[piso_sig];
        adelante_sig = |(ver & (sube ? mascara_arriba(piso_sig)
                                     : mascara_abajo(piso_sig)));
    end

    // Next state, floor step, direction memory and call clearing.
    always_comb begin
        estado_d = estado_q;
        piso_d   = piso_q;
        dir_d    = dir_q;
        borrar   = 4'b0000;
        extender = 1'b0;
        limite   = FIN_VIAJE;
        unique case (estado_q)
            REPOSO: begin
                if (aqui) begin
                    estado_d = PUERTAS;
                    borrar   = uno_caliente(piso_q);
                end else if (arriba && abajo) begin
                    estado_d = MOVIENDO;
                end else if (arriba) begin
                    estado_d = MOVIENDO;
                    dir_d    = DIR_SUBE;
                end else if (abajo) begin
                    estado_d = MOVIENDO;
                    dir_d    = DIR_BAJA;
                end
            end
            MOVIENDO: begin
                limite = FIN_VIAJE;
                if (fin) begin
                    piso_d = piso_sig;
                    if (ver_sig) begin
                        estado_d = PUERTAS;
                        borrar   = uno_caliente(piso_sig);
                    end else if (!adelante_sig) begin
                        estado_d = REPOSO;
                    end
                end
            end
            PUERTAS: begin
                limite   = FIN_PUERTA;
                borrar   = uno_caliente(piso_q);
                extender = llamadas[piso_q];
                if (!extender && fin) begin
                    if (sube ? arriba : abajo) begin
                        estado_d = MOVIENDO;
                    end else if (sube ? abajo : arriba) begin
                        estado_d = MOVIENDO;
                        dir_d    = sube ? DIR_BAJA : DIR_SUBE;
                    end else begin
                        estado_d = REPOSO;
                    end
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
        pend_d    = ver & ~borrar;
        habilitar = (estado_q != REPOSO);
        limpiar   = (estado_d != estado_q) || extender;
    end

    temporizador_asc #(
        .W(TW)
    ) u_temporizador (
        .clk      (clk),
        .rst_n    (rst_n),
        .limpiar  (limpiar),
        .habilitar(habilitar),
        .limite   (limite),
        .fin      (fin)
    );

    // State, floor, direction memory and call latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            piso_q   <= PISO_RESET;
            dir_q    <= DIR_SUBE;
            pend_q   <= 4'b0000;
        end else begin
            estado_q <= estado_d;
            piso_q   <= piso_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
        end
    end

    assign piso             = piso_q;
    assign direccion        = (estado_q == MOVIENDO) ? dir_q : DIR_NADA;
    assign puertas_abiertas = (estado_q == PUERTAS);
    assign pendientes       = pend_q;

endmodule

// File: tb/tb_planificador_asc.sv
// Bench for planificador_asc: table vectors, corner
// sequences and random calls against a floor-level model.
module tb_planificador_asc;

    localparam int TV = 4;
    localparam int TP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] llamadas;
    logic [1:0] piso;
    logic [1:0] direccion;
    logic       puertas_abiertas;
    logic [3:0] pendientes;

    planificador_asc #(
        .T_VIAJE   (TV),
        .T_PUERTA  (TP),
        .PISO_RESET(2'b00)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .llamadas        (llamadas),
        .piso            (piso),
        .direccion       (direccion),
        .puertas_abiertas(puertas_abiertas),
        .pendientes      (pendientes)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: floor index, +1/-1 heading, countdowns.
    int       m_floor;
    int       m_dir;
    int       m_left;
    bit       m_moving;
    bit       m_open;
    bit [3:0] m_pend;

    int q_abre[$];
    int q_dir[$];
    int pa_prev;
    int dir_prev;

    typedef struct {
        logic [3:0] ll;
        logic [1:0] piso;
        logic [1:0] dir;
        logic       pa;
        logic [3:0] pend;
    } vec_t;

    vec_t tabla[16];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit hay(input bit [3:0] v, input int desde, input int sentido);
        for (int f = desde + sentido; f >= 0 && f <= 3; f += sentido)
            if (v[f]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelo_reset();
        m_floor  = 0;
        m_dir    = 1;
        m_left   = 0;
        m_moving = 0;
        m_open   = 0;
        m_pend   = 4'b0000;
    endtask

    task automatic modelo_paso(input logic [3:0] ll);
        bit [3:0] ver;
        bit up, dn;
        ver = m_pend | ll;
        up  = hay(ver, m_floor, 1);
        dn  = hay(ver, m_floor, -1);
        if (m_open) begin
            m_pend = ver;
            m_pend[m_floor] = 1'b0;
            if (ll[m_floor]) begin
                m_left = TP;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_open = 0;
                    if (hay(ver, m_floor, m_dir)) begin
                        m_moving = 1;
                        m_left   = TV;
                    end else if (hay(ver, m_floor, -m_dir)) begin
                        m_dir    = -m_dir;
                        m_moving = 1;
                        m_left   = TV;
                    end
                end
            end
        end else if (m_moving) begin
            m_pend = ver;
            m_left--;
            if (m_left == 0) begin
                m_floor += m_dir;
                if (ver[m_floor]) begin
                    m_pend[m_floor] = 1'b0;
                    m_moving = 0;
                    m_open   = 1;
                    m_left   = TP;
                end else if (hay(ver, m_floor, m_dir)) begin
                    m_left = TV;
                end else begin
                    m_moving = 0;
                end
            end
        end else begin
            m_pend = ver;
            if (ver[m_floor]) begin
                m_pend[m_floor] = 1'b0;
                m_open = 1;
                m_left = TP;
            end else if (up || dn) begin
                if (!(up && dn)) m_dir = up ? 1 : -1;
                m_moving = 1;
                m_left   = TV;
            end
        end
    endtask

    task automatic comparar_modelo();
        chk("model piso", int'(piso), m_floor);
        chk("model direccion", int'(direccion),
            m_moving ? (m_dir > 0 ? 1 : 2) : 0);
        chk("model puertas", int'(puertas_abiertas), int'(m_open));
        chk("model pendientes", int'(pendientes), int'(m_pend));
    endtask

    task automatic ciclo(input logic [3:0] ll);
        llamadas = ll;
        @(posedge clk);
        modelo_paso(ll);
        @(negedge clk);
        comparar_modelo();
        if (puertas_abiertas && pa_prev == 0) q_abre.push_back(int'(piso));
        if (int'(direccion) != dir_prev) q_dir.push_back(int'(direccion));
        pa_prev  = int'(puertas_abiertas);
        dir_prev = int'(direccion);
    endtask

    task automatic esperar_reposo();
        int k;
        k = 0;
        do begin
            ciclo(4'b0000);
            k++;
        end while (!(direccion == 2'b00 && !puertas_abiertas) && k < 100);
        if (k >= 100) chk("idle timeout", 0, 1);
    endtask

    task automatic limpiar_traza();
        q_abre.delete();
        q_dir.delete();
        pa_prev  = int'(puertas_abiertas);
        dir_prev = int'(direccion);
    endtask

    initial begin
        int n;
        // Scenario: single call to floor 3 from idle at 00.
        for (int i = 0; i < 16; i++) begin
            tabla[i].ll   = (i == 0) ? 4'b1000 : 4'b0000;
            tabla[i].piso = (i < 4) ? 2'b00 : (i < 8) ? 2'b01 :
                            (i < 12) ? 2'b10 : 2'b11;
            tabla[i].dir  = (i < 12) ? 2'b01 : 2'b00;
            tabla[i].pa   = (i >= 12 && i < 15);
            tabla[i].pend = (i < 12) ? 4'b1000 : 4'b0000;
        end

        rst_n    = 1'b0;
        llamadas = 4'b0000;
        modelo_reset();
        repeat (2) @(negedge clk);
        chk("reset piso", int'(piso), 0);
        chk("reset direccion", int'(direccion), 0);
        chk("reset puertas", int'(puertas_abiertas), 0);
        chk("reset pendientes", int'(pendientes), 0);
        rst_n    = 1'b1;
        pa_prev  = 0;
        dir_prev = 0;

        for (int i = 0; i < 16; i++) begin
            ciclo(tabla[i].ll);
            chk($sformatf("vec%0d piso", i), int'(piso), int'(tabla[i].piso));
            chk($sformatf("vec%0d dir", i), int'(direccion), int'(tabla[i].dir));
            chk($sformatf("vec%0d puertas", i), int'(puertas_abiertas), int'(tabla[i].pa));
            chk($sformatf("vec%0d pend", i), int'(pendientes), int'(tabla[i].pend));
        end

        // Asynchronous reset in the middle of a downward trip.
        ciclo(4'b0001);
        ciclo(4'b0100);
        ciclo(4'b0000);
        #2 rst_n = 1'b0;
        #1;
        chk("async piso", int'(piso), 0);
        chk("async direccion", int'(direccion), 0);
        chk("async puertas", int'(puertas_abiertas), 0);
        chk("async pendientes", int'(pendientes), 0);
        modelo_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        pa_prev  = 0;
        dir_prev = 0;
        ciclo(4'b0000);
        ciclo(4'b0000);

        // SCAN ordering: 3 requested, then 2 and -1 during travel.
        limpiar_traza();
        ciclo(4'b1000);
        ciclo(4'b0100);
        ciclo(4'b0001);
        esperar_reposo();
        chk("scan stops", q_abre.size(), 3);
        chk("scan stop0", q_abre.size() > 0 ? q_abre[0] : -1, 2);
        chk("scan stop1", q_abre.size() > 1 ? q_abre[1] : -1, 3);
        chk("scan stop2", q_abre.size() > 2 ? q_abre[2] : -1, 0);

        // Call at current floor, then dwell extension.
        ciclo(4'b0010);
        esperar_reposo();
        n = 0;
        ciclo(4'b0010);
        chk("here puertas", int'(puertas_abiertas), 1);
        chk("here direccion", int'(direccion), 0);
        chk("here piso", int'(piso), 1);
        n += int'(puertas_abiertas);
        ciclo(4'b0000);
        n += int'(puertas_abiertas);
        ciclo(4'b0010);
        n += int'(puertas_abiertas);
        for (int k = 0; k < 10; k++) begin
            ciclo(4'b0000);
            n += int'(puertas_abiertas);
        end
        chk("dwell length", n, 5);

        // Tie: idle at 2 heading up, calls at 3 and -1 together.
        ciclo(4'b0100);
        esperar_reposo();
        limpiar_traza();
        ciclo(4'b1001);
        chk("tie first dir", int'(direccion), 1);
        esperar_reposo();
        chk("tie stops", q_abre.size(), 2);
        chk("tie stop0", q_abre.size() > 0 ? q_abre[0] : -1, 3);
        chk("tie stop1", q_abre.size() > 1 ? q_abre[1] : -1, 0);
        chk("tie dirs", q_dir.size(), 4);
        chk("tie dir0", q_dir.size() > 0 ? q_dir[0] : -1, 1);
        chk("tie dir1", q_dir.size() > 1 ? q_dir[1] : -1, 0);
        chk("tie dir2", q_dir.size() > 2 ? q_dir[2] : -1, 2);
        chk("tie dir3", q_dir.size() > 3 ? q_dir[3] : -1, 0);

        // Pulse for floor 3 while doors are open at floor 2.
        ciclo(4'b0100);
        n = 0;
        while (!puertas_abiertas && n < 20) begin
            ciclo(4'b0000);
            n++;
        end
        chk("latch doors at 2", int'(piso), 2);
        ciclo(4'b1000);
        chk("latch bit set", int'(pendientes[3]), 1);
        for (int k = 0; k < 40; k++) begin
            ciclo(4'b0000);
            if (puertas_abiertas && piso == 2'b11) break;
            chk("latch bit held", int'(pendientes[3]), 1);
        end
        chk("latch doors at 3", int'(puertas_abiertas && piso == 2'b11), 1);
        chk("latch cleared", int'(pendientes), 0);
        esperar_reposo();

        // Random call traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0)
                ciclo(4'($urandom_range(1, 15)));
            else
                ciclo(4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/planificador_asc.md
# planificador_asc

Call scheduler and motion sequencer for the four-stop elevator (floors −1, 1, 2, 3). It latches per-floor call buttons, chooses the travel direction with a SCAN (collective) policy, and times floor-to-floor travel and the door dwell. It drives the `piso` / `direccion` / `puertas_abiertas` outputs consumed by the floor display and the door logic. It replaces the fixed up/down sweep with demand-driven motion.

## Interface

- `T_VIAJE`, 50000000, cycles to travel one floor (≥2)
- `T_PUERTA`, 100000000, cycles doors stay open (≥2)
- `PISO_RESET`, 2'b00, floor held after reset

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `llamadas`  in  4  call buttons, bit i = floor code i; level or pulse, sampled every edge
- `piso`  out  2  current floor: 00 = −1, 01 = 1, 10 = 2, 11 = 3
- `direccion`  out  2  00 = stopped, 01 = up, 10 = down
- `puertas_abiertas`  out  1  doors open
- `pendientes`  out  4  latched, unserved calls

## Operation

**Call latch**
- Every edge: `pendientes <= (pendientes | llamadas) & ~borrar`.
- `borrar` is the one-hot of the floor whose doors open this edge, or of `piso` while in PUERTAS.

**Request view**
- `ver = pendientes | llamadas` (same-cycle calls count).
- `arriba` = any `ver` bit above `piso`.
- `abajo` = any `ver` bit below `piso`.
- `aqui` = `ver[piso]`.

**Direction memory**
- `dir_mem` holds the last committed direction. Reset value: up.

**FSM**
- REPOSO:
  - If `aqui`: go to PUERTAS.
  - Else if `arriba` and `abajo`: move in `dir_mem`.
  - Else if `arriba`: move up.
  - Else if `abajo`: move down.
  - Else: stay.
- MOVIENDO:
  - Timer counts 0..T_VIAJE−1.
  - On the terminal count, `piso` steps ±1 and the timer clears.
  - If the new floor's bit is set in `ver`: go to PUERTAS.
  - Else if calls remain ahead: stay in MOVIENDO.
  - Else: go to REPOSO (defensive; unreachable in normal use).
- PUERTAS:
  - Timer counts 0..T_PUERTA−1.
  - A call at `piso` during PUERTAS is cleared and restarts the timer at 0 (dwell extension).
  - On the terminal count:
    - Calls ahead in `dir_mem`: MOVIENDO, same direction.
    - Else calls behind: MOVIENDO, reversed, and `dir_mem` updated.
    - Else: REPOSO.

**Outputs**
- `direccion` = `dir_mem` encoding in MOVIENDO, 00 otherwise.
- `puertas_abiertas` = 1 exactly in PUERTAS.
- `piso` is never driven past 00 or 11. Moves are only launched toward an existing call.

**Reset**
- `rst_n` low forces, immediately and regardless of state:
  - `piso` = PISO_RESET
  - `direccion` = 00
  - `puertas_abiertas` = 0
  - `pendientes` = 0
  - timer = 0
  - state = REPOSO
  - `dir_mem` = up
- Mid-travel reset discards all pending calls and the partial timer count.

## Timing

- Call seen in REPOSO at edge n:
  - Latched at n.
  - MOVIENDO / PUERTAS registered at n (the combinational `ver` path).
  - Outputs change after edge n.
- Travel: `piso` updates T_VIAJE cycles after entering MOVIENDO. A PUERTAS transition happens on that same edge.
- Door: `puertas_abiertas` is high exactly T_PUERTA cycles unless extended.
- Leaving PUERTAS into MOVIENDO is a single edge. `direccion` goes 00 → 01/10 on that edge.
- Timer width: $clog2(max(T_VIAJE, T_PUERTA)). It is shared by both phases and cleared on every state change.

## Structure

- Package `asc_pkg`:
  - Floor codes: PISO_M1, PISO_1, PISO_2, PISO_3.
  - Direction codes: DIR_NADA, DIR_SUBE, DIR_BAJA.
  - State enum: REPOSO, MOVIENDO, PUERTAS.
- Sub-module `temporizador_asc`: loadable up-counter with `limpiar`, `habilitar`, parameterised terminal count, and a `fin` output. One instance serves both travel and dwell.
- Top level holds the latch, the above/below reduction logic, and the FSM.

## Test plan

All scenarios use T_VIAJE=4, T_PUERTA=3, PISO_RESET=00.

1. **Reset**: assert `rst_n`=0 mid-operation → `piso`=00, `direccion`=00, `puertas_abiertas`=0, `pendientes`=0000 without waiting for a clock edge.
2. **Single call to floor 3**: one-cycle `llamadas`=1000 from idle at 00 → `direccion`=01 for 12 cycles, `piso` 01/10/11 at 4-cycle spacing, then `puertas_abiertas`=1 for 3 cycles, `pendientes`=0000, `direccion`=00.
3. **SCAN ordering**: moving up from 00 toward 11; calls 0100 and 0001 arrive during the first travel → stops at 10, then 11, then travels down to 00. `pendientes` bits clear in that order.
4. **Call at current floor**: at 01 idle, `llamadas`=0010 → doors open on the same edge with no motion. Re-pressing 0010 on dwell cycle 2 extends the open time to 5 cycles total.
5. **Tie with simultaneous call**: `dir_mem`=up, idle at 10, `llamadas`=1001 in one cycle → moves up to 11 first, then down to 00. `direccion` is 01, then 00 during dwell, then 10.
6. **Latch persistence**: a one-cycle pulse on an unserved floor while doors are open at another floor → the bit stays in `pendientes` until that floor's doors open.
